// File: rtl/bcd_deci_seq_if.sv
// bcd_deci_seq_if: word-in / result-out valid-ready bundle for the BCD-to-binary converter
interface bcd_deci_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14
);
  logic [4*DIGITS-1:0] bcd_in;
  logic in_valid;
  logic in_ready;
  logic [BIN_W-1:0] bin_out;
  logic err;
  logic out_valid;
  logic out_ready;
  modport master(output bcd_in, in_valid, out_ready, input in_ready, bin_out, err, out_valid);
  modport slave(input bcd_in, in_valid, out_ready, output in_ready, bin_out, err, out_valid);
endinterface

// File: rtl/bcd_deci_seq.sv
// bcd_deci_seq: sequential BCD-to-binary converter, one digit per cycle, most significant first
module bcd_deci_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14
) (
  input logic clk,
  input logic rst,
  bcd_deci_seq_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state;
  logic [4*DIGITS-1:0] sr;
  logic [BIN_W-1:0] acc, acc_n;
  logic [BIN_W+3:0] ax;
  logic [3:0] d;
  logic [CW-1:0] cnt;
  logic e, e_n;
  // acc*10 + d computed at BIN_W+4 bits then truncated; digits above 9 raise the error
  always_comb begin
    d = sr[4*DIGITS-1 -: 4];
    ax = {4'b0, acc};
    acc_n = BIN_W'((ax << 3) + (ax << 1) + {{BIN_W{1'b0}}, d});
    e_n = e | (d > 4'd9);
  end
  assign bus.in_ready = state == IDLE && !rst;
  // control FSM with registered result outputs
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      e <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.bin_out <= '0;
      bus.err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid) begin
            sr <= bus.bcd_in;
            acc <= '0;
            e <= 1'b0;
            cnt <= CW'(DIGITS);
            state <= CONV;
          end
        CONV: begin
          acc <= acc_n;
          e <= e_n;
          sr <= sr << 4;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            bus.bin_out <= e_n ? '0 : acc_n;
            bus.err <= e_n;
          end
        end
        DONE:
          if (bus.out_ready) begin
            state <= IDLE;
            bus.out_valid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_bcd_deci_seq.sv
// tb_bcd_deci_seq: scoreboard bench for bcd_deci_seq with a decimal reference model
module tb_bcd_deci_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit rand_or = 1'b0;
  typedef struct {
    int bin;
    int e;
    int ae;
  } exp_t;
  exp_t q[$];
  bit pres = 1'b0;
  bit chk_rdy = 1'b0;
  int last_acc = 0;
  int prev_acc = 0;
  bcd_deci_seq_if #(.DIGITS(4), .BIN_W(14)) bus();
  bcd_deci_seq_if #(.DIGITS(2), .BIN_W(7)) b2();
  bcd_deci_seq #(.DIGITS(4), .BIN_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));
  bcd_deci_seq #(.DIGITS(2), .BIN_W(7)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask
  // decimal value of the word as a number; any non-decimal digit forces the error result
  function automatic exp_t model(input logic [15:0] w, input int ae);
    exp_t r;
    int v = 0;
    int p = 1;
    int bad = 0;
    for (int k = 0; k < 4; k++) begin
      int dg = int'(w[4*k +: 4]);
      if (dg > 9) bad = 1;
      v += dg * p;
      p *= 10;
    end
    r.bin = bad ? 0 : v % 16384;
    r.e = bad;
    r.ae = ae;
    return r;
  endfunction
  // accept tracking and result checking, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pres = 1'b0;
      chk_rdy = 1'b0;
    end else begin
      if (chk_rdy) begin
        chk("in_ready_after_handshake", bus.in_ready, 1);
        chk_rdy = 1'b0;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", bus.out_valid, 0);
        else begin
          if (!pres) begin
            chk("latency", cyc - q[0].ae, 4);
            pres = 1'b1;
          end
          chk("bin_out", bus.bin_out, q[0].bin);
          chk("err", bus.err, q[0].e);
          chk("in_ready_busy", bus.in_ready, 0);
          if (bus.out_ready) begin
            void'(q.pop_front());
            pres = 1'b0;
            chk_rdy = 1'b1;
          end
        end
      end else if (pres) begin
        chk("out_valid_dropped", bus.out_valid, 1);
        void'(q.pop_front());
        pres = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.bcd_in, cyc + 1));
        prev_acc = last_acc;
        last_acc = cyc + 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.bcd_in = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("accept_timeout", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.bcd_in = 16'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && bus.in_ready) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", q.size(), 0);
  endtask
  initial begin
    int n;
    logic [15:0] w;
    bus.bcd_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    b2.bcd_in = '0;
    b2.in_valid = 1'b0;
    b2.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_bin_out", bus.bin_out, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    tick();
    chk("post_rst_out_valid", bus.out_valid, 0);
    send(16'h1234);
    wait_idle();
    send(16'h9999);
    send(16'h0000);
    chk("accept_gap", last_acc - prev_acc, 6);
    wait_idle();
    send(16'h12A4);
    wait_idle();
    bus.out_ready = 1'b0;
    send(16'h0042);
    repeat (10) begin
      tick();
      bus.in_valid = ~bus.in_valid;
      bus.bcd_in = 16'($urandom);
    end
    chk("hold_out_valid", bus.out_valid, 1);
    chk("hold_bin_out", bus.bin_out, 42);
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    wait_idle();
    send(16'h5678);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_bin_out", bus.bin_out, 0);
    chk("abort_err", bus.err, 0);
    repeat (6) tick();
    send(16'h0007);
    wait_idle();
    rand_or = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++)
        w[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) tick();
      send(w);
    end
    rand_or = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    b2.bcd_in = 8'h99;
    b2.in_valid = 1'b1;
    tick();
    b2.in_valid = 1'b0;
    n = 0;
    while (!b2.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("v2_latency", n, 2);
    chk("v2_bin_out", b2.bin_out, 99);
    chk("v2_err", b2.err, 0);
    tick();
    b2.bcd_in = 8'hB3;
    b2.in_valid = 1'b1;
    tick();
    b2.in_valid = 1'b0;
    n = 0;
    while (!b2.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("v2_err_latency", n, 2);
    chk("v2_err_bin_out", b2.bin_out, 0);
    chk("v2_err_flag", b2.err, 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
